// File: rtl/lab_pkg.sv
// Shared lab types and constants for the seven-segment display path.
// Holds the formatter FSM state type and the display code indices.
package lab_pkg;

  localparam int SEVSEG_BLANK_INDEX = 16;
  localparam int SEVSEG_LINE_INDEX  = 17;
  localparam int SEVSEG_NUM_DIGITS  = 6;
  localparam int SEVSEG_CODE_WIDTH  = 5;

  localparam logic [SEVSEG_CODE_WIDTH-1:0] SEVSEG_BLANK_CODE =
    SEVSEG_CODE_WIDTH'(SEVSEG_BLANK_INDEX);
  localparam logic [SEVSEG_CODE_WIDTH-1:0] SEVSEG_LINE_CODE =
    SEVSEG_CODE_WIDTH'(SEVSEG_LINE_INDEX);

  typedef enum logic [1:0] {
    FMT_IDLE,
    FMT_CONVERT,
    FMT_FORMAT
  } fmt_state_t;

endpackage

// File: rtl/bcd_add3_stage.sv
// Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
// Ports: i_bcd packed BCD nibbles in, o_bcd corrected nibbles out.
module bcd_add3_stage #(
  parameter int NUM_NIBBLES = 5
) (
  input  logic [4*NUM_NIBBLES-1:0] i_bcd,
  output logic [4*NUM_NIBBLES-1:0] o_bcd
);

  always_comb begin
    o_bcd = i_bcd;
    for (int i = 0; i < NUM_NIBBLES; i++) begin
      if (i_bcd[4*i +: 4] >= 4'd5)
        o_bcd[4*i +: 4] = i_bcd[4*i +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/sevseg_value_formatter.sv
// Converts a 16-bit value into per-digit 5-bit seven-segment codes.
// Ports: clk, reset (async high), start/data/hex_mode in; busy, done, digits out.
module sevseg_value_formatter
  import lab_pkg::*;
#(
  parameter int NUM_DIGITS = SEVSEG_NUM_DIGITS,
  parameter int DATA_WIDTH = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [DATA_WIDTH-1:0]                   data,
  input  logic                                    hex_mode,
  output logic                                    busy,
  output logic                                    done,
  output logic [NUM_DIGITS*SEVSEG_CODE_WIDTH-1:0] digits
);

  localparam int CW      = SEVSEG_CODE_WIDTH;
  localparam int BCD_N   = NUM_DIGITS - 1;
  localparam int BCD_W   = 4 * BCD_N;
  localparam int HEX_N   = DATA_WIDTH / 4;
  localparam int CNT_W   = $clog2(DATA_WIDTH);
  localparam int MSD_W   = $clog2(NUM_DIGITS);

  fmt_state_t               r_state;
  logic                     r_hex;
  logic                     r_neg;
  logic [DATA_WIDTH-1:0]    r_mag;
  logic [BCD_W-1:0]         r_bcd;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_busy;
  logic                     r_done;
  logic [NUM_DIGITS*CW-1:0] r_digits;

  logic [BCD_W-1:0]         w_bcd_adj;
  logic [MSD_W-1:0]         w_msd;
  logic                     w_neg_show;
  logic [NUM_DIGITS*CW-1:0] w_fmt;

  bcd_add3_stage #(
    .NUM_NIBBLES(BCD_N)
  ) u_add3 (
    .i_bcd(r_bcd),
    .o_bcd(w_bcd_adj)
  );

  // w_msd: highest nonzero BCD nibble; stays 0 so digit 0 is never blank.
  always_comb begin
    w_msd = '0;
    for (int i = 1; i < BCD_N; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0)
        w_msd = MSD_W'(i);
    end
    w_neg_show = r_neg && (r_bcd != '0);
    w_fmt = {NUM_DIGITS{SEVSEG_BLANK_CODE}};
    if (r_hex) begin
      for (int i = 0; i < HEX_N; i++)
        w_fmt[CW*i +: CW] = CW'(r_mag[4*i +: 4]);
    end else begin
      for (int i = 0; i < BCD_N; i++) begin
        if (i <= int'(w_msd))
          w_fmt[CW*i +: CW] = CW'(r_bcd[4*i +: 4]);
      end
      for (int i = 1; i < NUM_DIGITS; i++) begin
        if (w_neg_show && (i == int'(w_msd) + 1))
          w_fmt[CW*i +: CW] = SEVSEG_LINE_CODE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= FMT_IDLE;
      r_hex    <= 1'b0;
      r_neg    <= 1'b0;
      r_mag    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_digits <= {NUM_DIGITS{SEVSEG_BLANK_CODE}};
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        FMT_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_hex  <= hex_mode;
            r_bcd  <= '0;
            r_cnt  <= '0;
            if (hex_mode) begin
              r_neg   <= 1'b0;
              r_mag   <= data;
              r_state <= FMT_FORMAT;
            end else begin
              r_neg   <= data[DATA_WIDTH-1];
              // -32768 negates to itself, which reads as 32768 unsigned
              r_mag   <= data[DATA_WIDTH-1] ? (~data + 1'b1) : data;
              r_state <= FMT_CONVERT;
            end
          end
        end
        FMT_CONVERT: begin
          {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_WIDTH - 1))
            r_state <= FMT_FORMAT;
        end
        FMT_FORMAT: begin
          r_digits <= w_fmt;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= FMT_IDLE;
        end
        default: r_state <= FMT_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign digits = r_digits;

endmodule

// File: doc/sevseg_value_formatter.md
# sevseg_value_formatter

Sequential producer of seven-segment digit indices. It converts a 16-bit processor value into per-digit 5-bit display codes, either signed decimal or hexadecimal. Each code is consumed by one `sevseg_display` instance per HEX digit. The block sits between the processor's display register and the bank of segment decoders on the board.

## Interface
Parameters:
- `NUM_DIGITS`, default 6: number of digit codes output; fixed at 6 for a 16-bit signed value (sign + 5 digits).
- `DATA_WIDTH`, default 16: width of `data`.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a conversion; sampled only in IDLE.
- `data`  in  DATA_WIDTH  value to display; sampled with `start`.
- `hex_mode`  in  1  1 = unsigned hex, 0 = signed two's-complement decimal; sampled with `start`.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when `digits` has just been updated.
- `digits`  out  NUM_DIGITS*5  packed codes; digit 0 (rightmost) in [4:0], digit 5 in [29:25]. Codes: 0–15 glyph, 16 = blank, 17 = line (minus).

## Operation
- States: IDLE, CONVERT, FORMAT.
- IDLE and `start`=1:
  - latch `hex_mode`; set `busy`.
  - hex: load `data` into the shift register, go to FORMAT.
  - decimal: latch sign = `data[15]` and magnitude = |data| as 16-bit unsigned (-32768 → 32768); clear the 20-bit BCD register and the bit counter; go to CONVERT.
- CONVERT: double-dabble, one bit per cycle.
  - each BCD nibble ≥5 gets +3.
  - then shift {BCD, magnitude} left by one.
  - after 16 shifts, go to FORMAT.
- FORMAT: one cycle; register all digit codes, pulse `done`, clear `busy`, return to IDLE.
- Hex formatting: digits 0–3 = nibbles `data[3:0]`..`data[15:12]`; digits 4–5 = 16. No leading-zero blanking.
- Decimal formatting:
  - digits 0–4 = BCD nibbles.
  - leading zeros are replaced by 16; digit 0 is never blanked.
  - if negative, the position immediately left of the most significant displayed digit gets 17 (always ≤ digit 5).
  - digit 5 is otherwise 16.
  - zero is never negative.
- `start` while `busy`: ignored, no queueing.
- `digits` holds its previous value during a conversion (no flicker).
- `data`/`hex_mode` changes after sampling have no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, every digit code = 16 (all blank), internal registers 0.
- `start` sampled at edge E0; `busy` is high from after E0.
- Decimal: CONVERT occupies E1–E16, FORMAT at E17. `digits` valid and `done`=1 after E17; `busy`=0 after E17.
- Hex: FORMAT at E1. `digits`/`done` update after E1.
- `done` is high for exactly one cycle. A new `start` is accepted in the cycle `done` is high (state is IDLE).
- Reset asserted mid-conversion: immediate return to the reset values; the partial result is discarded and no `done` pulse occurs.

## Structure
- Add to `lab_pkg`:
  - `typedef enum logic [1:0] {FMT_IDLE, FMT_CONVERT, FMT_FORMAT} fmt_state_t`
  - `SEVSEG_NUM_DIGITS = 6`
  - `SEVSEG_CODE_WIDTH = 5`
- Reuse the existing `SEVSEG_BLANK_INDEX` (16) and `SEVSEG_LINE_INDEX` (17); no literal 16/17 in RTL.
- One sub-module, `bcd_add3_stage`: combinational, 20-bit BCD in, per-nibble +3 correction out. The FSM, counter and formatting logic stay in the top module.
- A board top instantiates this block plus NUM_DIGITS `sevseg_display` instances, one per 5-bit slice.

## Test plan
- Reset → `digits` = all 16, `busy`=0, `done`=0. Reset released, no `start` → outputs unchanged for 50 cycles.
- Decimal `data`=1234 → `done` pulse 17 edges after the start edge; digits[5..0] = 16,16,1,2,3,4; `busy` high for exactly 17 cycles.
- Decimal `data`=0 → 16,16,16,16,16,0. `data`=-5 → 16,16,16,16,17,5. `data`=-32768 → 17,3,2,7,6,8.
- Hex `data`=0xBEEF → `done` after E1; 16,16,11,14,14,15. Hex `data`=0x0000 → 16,16,0,0,0,0.
- `start` pulses with `data`=999 on every cycle of a conversion of 42 → result 16,16,16,16,4,2 with a single `done`. A `start` during the `done` cycle is accepted.
- Reset asserted at the 8th CONVERT cycle of 12345 → all-blank digits immediately and no `done`. A following conversion of 7 → 16,16,16,16,16,7.
